// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, field widths and fetch FSM states.
// Used by fetch_unit (optional NOP_SKIP_EN build) and the decoder.
package cpu_pkg;

  localparam int OPC_W = 5;
  localparam int OPR_W = 12;
  localparam int WORD_W = OPC_W + OPR_W;

  localparam logic [OPC_W-1:0] JPNZ = 5'd24;
  localparam logic [OPC_W-1:0] JMPZ = 5'd26;
  localparam logic [OPC_W-1:0] NOP = 5'd28;
  localparam logic [OPC_W-1:0] ENDOP = 5'd31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ISSUE = 2'd1,
    HOLD = 2'd2,
    HALT = 2'd3
  } fetch_state_t;

  function automatic logic is_branch(
    input logic [OPC_W-1:0] op
  );
    return (op == JPNZ) || (op == JMPZ);
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, IR and IDLE/ISSUE/HOLD/HALT sequencer.
// Define NOP_SKIP_EN to drop fetched nops before they reach execute.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int INSTR_W = 17
) (
  input logic clk,
  input logic rst,
  input logic start,
  output logic [ADDR_W-1:0] pc_addr,
  input logic [INSTR_W-1:0] instr_in,
  output logic ir_valid,
  input logic ir_ready,
  input logic br_taken,
  output logic [INSTR_W-1:0] ir_out,
  output logic halted,
  output logic [15:0] instr_cnt
);

  fetch_state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic halted_q, halted_d;
  logic [15:0] cnt_q, cnt_d;

  logic [OPC_W-1:0] ir_op;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] pc_next;
  logic [15:0] cnt_inc;

  assign ir_op = ir_q[INSTR_W-1 -: OPC_W];
  assign pc_inc = pc_q + 1'b1;
  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  always_comb begin
    pc_next = pc_inc;
    if (is_branch(ir_op) && br_taken)
      pc_next = ir_q[ADDR_W-1:0];
  end

`ifdef NOP_SKIP_EN
  logic is_nop;
  assign is_nop = instr_in[INSTR_W-1 -: OPC_W] == NOP;
`endif

  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    ir_d = ir_q;
    halted_d = halted_q;
    cnt_d = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          pc_d = '0;
          cnt_d = '0;
        end
      end
      ISSUE: begin
`ifdef NOP_SKIP_EN
        if (is_nop) begin
          pc_d = pc_inc;
        end else begin
          ir_d = instr_in;
          state_d = HOLD;
        end
`else
        ir_d = instr_in;
        state_d = HOLD;
`endif
      end
      HOLD: begin
        if (ir_ready) begin
          cnt_d = cnt_inc;
          if (ir_op == ENDOP) begin
            halted_d = 1'b1;
            state_d = HALT;
          end else begin
            pc_d = pc_next;
            state_d = ISSUE;
          end
        end
      end
      HALT: begin
        if (start) begin
          halted_d = 1'b0;
          pc_d = '0;
          cnt_d = '0;
          state_d = ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q <= '0;
      ir_q <= '0;
      halted_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
      halted_q <= halted_d;
      cnt_q <= cnt_d;
    end
  end

  // The memory samples the next PC at the edge that commits it,
  // so its data is ready during the following ISSUE cycle.
  assign pc_addr = pc_d;
  assign ir_valid = state_q == HOLD;
  assign ir_out = ir_q;
  assign halted = halted_q;
  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a 1-cycle registered memory.
// Build with or without NOP_SKIP_EN to match the RTL.
module tb_fetch_unit;
  import cpu_pkg::*;

  localparam int AW = 11;
  localparam int IW = 17;
  localparam logic [4:0] LDAC = 5'd1;
  localparam logic [4:0] INAC = 5'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [AW-1:0] pc_addr;
  logic [IW-1:0] instr_in = '0;
  logic ir_valid;
  logic ir_ready = 1'b0;
  logic br_taken = 1'b0;
  logic [IW-1:0] ir_out;
  logic halted;
  logic [15:0] instr_cnt;

  logic [IW-1:0] mem [2048];
  int n_cmp = 0;
  int n_bad = 0;

  fetch_unit #(.ADDR_W(AW), .INSTR_W(IW)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .pc_addr(pc_addr),
    .instr_in(instr_in),
    .ir_valid(ir_valid),
    .ir_ready(ir_ready),
    .br_taken(br_taken),
    .ir_out(ir_out),
    .halted(halted),
    .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) instr_in <= mem[pc_addr];

  function automatic logic [IW-1:0] mk(
    input logic [4:0] op,
    input logic [11:0] opr
  );
    return {op, opr};
  endfunction

  task automatic check(
    input string tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_hold(input string tag);
    int n = 0;
    while (!ir_valid && n < 8) begin
      tick();
      n++;
    end
    check(tag, 32'(ir_valid), 32'd1);
  endtask

  task automatic accept(input logic bt);
    ir_ready = 1'b1;
    br_taken = bt;
    tick();
    ir_ready = 1'b0;
    br_taken = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int first;
    for (int i = 0; i < 2048; i++) mem[i] = '0;
    @(negedge clk);
    tick();
    rst = 1'b0;
    tick();
    check("rst_pc", 32'(pc_addr), 32'd0);
    check("rst_ir", 32'(ir_out), 32'd0);
    check("rst_vld", 32'(ir_valid), 32'd0);
    check("rst_halt", 32'(halted), 32'd0);
    check("rst_cnt", 32'(instr_cnt), 32'd0);

    // sequential fetch, instructions at cycles 2, 4, 6
    mem[0] = mk(LDAC, 12'h005);
    mem[1] = mk(INAC, 12'h000);
    mem[2] = mk(ENDOP, 12'h000);
    pulse_start();
    ir_ready = 1'b1;
    check("seq_c1_vld", 32'(ir_valid), 32'd0);
    tick();
    check("seq_c2_vld", 32'(ir_valid), 32'd1);
    check("seq_c2_ir", 32'(ir_out), 32'(mk(LDAC, 12'h005)));
    tick();
    check("seq_c3_vld", 32'(ir_valid), 32'd0);
    tick();
    check("seq_c4_ir", 32'(ir_out), 32'(mk(INAC, 12'h000)));
    check("seq_c4_vld", 32'(ir_valid), 32'd1);
    tick();
    tick();
    check("seq_c6_ir", 32'(ir_out), 32'(mk(ENDOP, 12'h000)));
    check("seq_c6_vld", 32'(ir_valid), 32'd1);
    tick();
    ir_ready = 1'b0;
    check("seq_halt", 32'(halted), 32'd1);
    check("seq_cnt", 32'(instr_cnt), 32'd3);
    check("seq_vld0", 32'(ir_valid), 32'd0);

    // branch taken / not taken
    mem[0] = mk(JMPZ, 12'd29);
    mem[29] = mk(JPNZ, 12'd40);
    mem[30] = mk(ENDOP, 12'h000);
    mem[40] = mk(ENDOP, 12'h001);
    pulse_start();
    check("br_halt_clr", 32'(halted), 32'd0);
    wait_hold("br_h0");
    check("br_ir0", 32'(ir_out), 32'(mk(JMPZ, 12'd29)));
    accept(1'b1);
    check("br_pc29", 32'(pc_addr), 32'd29);
    wait_hold("br_h1");
    check("br_ir29", 32'(ir_out), 32'(mk(JPNZ, 12'd40)));
    accept(1'b1);
    check("br_pc40", 32'(pc_addr), 32'd40);
    wait_hold("br_h2");
    check("br_ir40", 32'(ir_out), 32'(mk(ENDOP, 12'h001)));
    accept(1'b0);
    check("br_halt", 32'(halted), 32'd1);
    pulse_start();
    check("br2_cnt0", 32'(instr_cnt), 32'd0);
    wait_hold("br2_h0");
    accept(1'b1);
    wait_hold("br2_h1");
    accept(1'b0);
    check("br_pc30", 32'(pc_addr), 32'd30);
    wait_hold("br2_h2");
    check("br_ir30", 32'(ir_out), 32'(mk(ENDOP, 12'h000)));
    accept(1'b0);
    check("br2_cnt", 32'(instr_cnt), 32'd3);

    // backpressure
    mem[0] = mk(LDAC, 12'h00A);
    mem[1] = mk(INAC, 12'h000);
    mem[2] = mk(ENDOP, 12'h000);
    pulse_start();
    wait_hold("bp_h0");
    for (int i = 0; i < 5; i++) begin
      br_taken = 1'b1;
      tick();
      check("bp_ir", 32'(ir_out), 32'(mk(LDAC, 12'h00A)));
      check("bp_pc", 32'(pc_addr), 32'd0);
      check("bp_vld", 32'(ir_valid), 32'd1);
    end
    br_taken = 1'b0;
    check("bp_cnt0", 32'(instr_cnt), 32'd0);
    accept(1'b0);
    check("bp_pc1", 32'(pc_addr), 32'd1);
    check("bp_cnt1", 32'(instr_cnt), 32'd1);
    wait_hold("bp_h1");
    accept(1'b0);
    wait_hold("bp_h2");
    accept(1'b0);
    check("bp_halt", 32'(halted), 32'd1);

    // wrap; operand 0xFFF also exercises the dropped top bit
    mem[0] = mk(JMPZ, 12'hFFF);
    mem[2047] = mk(LDAC, 12'h007);
    pulse_start();
    wait_hold("wr_h0");
    accept(1'b1);
    check("wr_pc2047", 32'(pc_addr), 32'd2047);
    wait_hold("wr_h1");
    check("wr_ir", 32'(ir_out), 32'(mk(LDAC, 12'h007)));
    accept(1'b1);
    check("wr_pc0", 32'(pc_addr), 32'd0);
    check("wr_cnt", 32'(instr_cnt), 32'd2);

    // reset while in ISSUE, start held high throughout
    rst = 1'b1;
    start = 1'b1;
    tick();
    check("mr_pc", 32'(pc_addr), 32'd0);
    check("mr_ir", 32'(ir_out), 32'd0);
    check("mr_vld", 32'(ir_valid), 32'd0);
    check("mr_halt", 32'(halted), 32'd0);
    check("mr_cnt", 32'(instr_cnt), 32'd0);
    tick();
    check("mr_vld2", 32'(ir_valid), 32'd0);
    rst = 1'b0;
    start = 1'b0;
    tick();
    tick();
    tick();
    check("mr_idle", 32'(ir_valid), 32'd0);
    check("mr_idle_ir", 32'(ir_out), 32'd0);

    // nop handling
    mem[0] = mk(NOP, 12'h000);
    mem[1] = mk(NOP, 12'h000);
    mem[2] = mk(ENDOP, 12'h000);
    pulse_start();
    ir_ready = 1'b1;
    cyc = 1;
    first = -1;
    while (!halted && cyc < 40) begin
      if (ir_valid && ir_out[16:12] == ENDOP && first < 0)
        first = cyc;
      tick();
      cyc++;
    end
    ir_ready = 1'b0;
    check("nop_halt", 32'(halted), 32'd1);
`ifdef NOP_SKIP_EN
    check("nop_endcyc", 32'(first), 32'd4);
    check("nop_cnt", 32'(instr_cnt), 32'd1);
`else
    check("nop_endcyc", 32'(first), 32'd6);
    check("nop_cnt", 32'(instr_cnt), 32'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
